// File: rtl/instr_encoder.sv
// RV32I instruction-word encoder feeding instruction memory through a small output FIFO.
// Optional: define INSTR_ENCODER_RANGE_CHECK_EN to reject out-of-range or misaligned immediates.
package instr_type;
    typedef enum logic [3:0] {
        lui, auipc, jal, jalr, branch_type, load_type, store_type,
        imm_arith_type, reg_arith_type, fence_type, system_type, invalid
    } opcode_t;
endpackage

module instr_encoder
    import instr_type::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  opcode_t           in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [15:0]       count
);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [31:0] word;
    logic        kind_ok;
    logic        range_ok;
    logic        is_shift;

    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    always_comb begin
        word    = '0;
        kind_ok = 1'b1;
        case (in_kind)
            lui:            word = {in_imm[31:12], in_rd, 7'b0110111};
            auipc:          word = {in_imm[31:12], in_rd, 7'b0010111};
            jal:            word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                    in_rd, 7'b1101111};
            jalr:           word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            branch_type:    word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                    in_imm[4:1], in_imm[11], 7'b1100011};
            load_type:      word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            store_type:     word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                                    7'b0100011};
            imm_arith_type: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (is_shift)
                    word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            reg_arith_type: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            fence_type:     word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0001111};
            system_type:    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1110011};
            default:        kind_ok = 1'b0;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic i_ok, b_ok, j_ok, u_ok, sh_ok;
    assign i_ok  = (&in_imm[31:11]) || ~|in_imm[31:11];
    assign b_ok  = ((&in_imm[31:12]) || ~|in_imm[31:12]) && !in_imm[0];
    assign j_ok  = ((&in_imm[31:20]) || ~|in_imm[31:20]) && !in_imm[0];
    assign u_ok  = ~|in_imm[11:0];
    assign sh_ok = ~|in_imm[31:5];

    always_comb begin
        range_ok = i_ok;
        case (in_kind)
            lui, auipc:     range_ok = u_ok;
            jal:            range_ok = j_ok;
            branch_type:    range_ok = b_ok;
            imm_arith_type: range_ok = is_shift ? sh_ok : i_ok;
            reg_arith_type: range_ok = 1'b1;
            default:        range_ok = i_ok;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    logic [PW:0]                  wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0][31:0]       instr_q, instr_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0]            next_addr_q, next_addr_d;
    logic                         err_q, err_d;
    logic [15:0]                  count_q, count_d;
    logic                         full, empty, accept, push, pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign in_ready = !full;
    assign accept   = in_valid && !full;
    assign push     = accept && kind_ok && range_ok;
    assign pop      = !empty && out_ready;

    always_comb begin
        wr_d        = wr_q;
        rd_d        = rd_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        count_d     = count_q;
        err_d       = accept && !(kind_ok && range_ok);
        if (push) begin
            instr_d[wr_q[PW-1:0]] = word;
            addr_d[wr_q[PW-1:0]]  = next_addr_q;
            wr_d                  = wr_q + PTR_ONE;
            next_addr_d           = next_addr_q + ADDR_W'(4);
        end
        if (pop) begin
            rd_d    = rd_q + PTR_ONE;
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q        <= '0;
            rd_q        <= '0;
            instr_q     <= '0;
            addr_q      <= {DEPTH{BASE_ADDR}};
            next_addr_q <= BASE_ADDR;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = !empty;
    assign out_instr = instr_q[rd_q[PW-1:0]];
    assign out_addr  = addr_q[rd_q[PW-1:0]];
    assign err       = err_q;
    assign count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, FIFO flow control, err, address wrap, reset flush.
module tb_instr_encoder;
    import instr_type::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0, out_ready_a = 1'b0, out_ready_b = 1'b0;
    opcode_t     in_kind = invalid;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;

    logic        in_ready_a, out_valid_a, err_a, in_ready_b, out_valid_b, err_b;
    logic [31:0] out_instr_a, out_addr_a, out_instr_b, out_addr_b;
    logic [15:0] count_a, count_b;

    int          checks = 0, failures = 0;
    logic [63:0] q_a[$];

    always #5 clk = ~clk;

    instr_encoder dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_instr(out_instr_a), .out_addr(out_addr_a), .err(err_a), .count(count_a)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_instr(out_instr_b), .out_addr(out_addr_b), .err(err_b), .count(count_b)
    );

    // Record every pop of dut_a as {addr, instr}; sampled mid-cycle ahead of the handshake edge.
    always @(negedge clk)
        if (!rst && out_valid_a && out_ready_a) q_a.push_back({out_addr_a, out_instr_a});

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic send(input bit sel, input opcode_t k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n = 0;
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        while (!(sel ? in_ready_b : in_ready_a) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q_a.delete();
    endtask

    logic [63:0] exp2[3] = '{{32'h0, 32'h12345137}, {32'h4, 32'h002081B3}, {32'h8, 32'h402081B3}};
    logic [63:0] exp7[6] = '{{32'h00, 32'hFFDFF06F}, {32'h04, 32'h00001297}, {32'h08, 32'h000280E7},
                             {32'h0C, 32'hFFC12303}, {32'h10, 32'h4033D393}, {32'h14, 32'h00000073}};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_instr", out_instr_a, 0);
        chk("rst_out_addr", out_addr_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_addr_b", out_addr_b, 32'hFFFF_FFFC);

        // ADDI x1,x0,5 on empty FIFO: visible the cycle after the handshake
        send(0, imm_arith_type, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5);
        chk("t1_valid", out_valid_a, 1);
        chk("t1_instr", out_instr_a, 32'h00500093);
        chk("t1_addr", out_addr_a, 0);
        chk("t1_err", err_a, 0);

        // LUI / ADD / SUB streamed with the consumer always ready; unused fields carry junk
        do_reset();
        out_ready_a = 1'b1;
        send(0, lui, 5'd2, 5'd31, 5'd31, 3'b111, 7'h7F, 32'h12345000);
        send(0, reg_arith_type, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFF_FFFF);
        send(0, reg_arith_type, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'h0);
        repeat (4) @(posedge clk);
        #1 out_ready_a = 1'b0;
        chk("t2_n", 64'(q_a.size()), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t2_w%0d", i), (i < q_a.size()) ? q_a[i] : '1, exp2[i]);
        chk("t2_count", count_a, 3);

        // BEQ + SW with consumer stalled: fills FIFO, head holds, no pass-through when full
        do_reset();
        send(0, branch_type, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd8);
        send(0, store_type, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd4);
        chk("t3_full_ready", in_ready_a, 0);
        chk("t3_head", out_instr_a, 32'h00208463);
        chk("t3_head_addr", out_addr_a, 0);
        repeat (2) @(posedge clk);
        #1 chk("t3_hold", out_instr_a, 32'h00208463);
        in_kind = system_type; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
        in_valid_a = 1'b1; out_ready_a = 1'b1;
        @(posedge clk);
        #1 in_valid_a = 1'b0; out_ready_a = 1'b0;
        chk("t3_next", out_instr_a, 32'h0020A223);
        chk("t3_next_addr", out_addr_a, 4);
        chk("t3_count1", count_a, 1);
        chk("t3_ready", in_ready_a, 1);
        out_ready_a = 1'b1;
        @(posedge clk);
        #1 out_ready_a = 1'b0;
        chk("t3_empty", out_valid_a, 0);
        chk("t3_count2", count_a, 2);

        // invalid kind between two valid requests
        do_reset();
        out_ready_a = 1'b1;
        send(0, imm_arith_type, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5);
        chk("t4_err_lo0", err_a, 0);
        send(0, invalid, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'd0);
        chk("t4_err_hi", err_a, 1);
        send(0, reg_arith_type, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0);
        chk("t4_err_lo1", err_a, 0);
        repeat (4) @(posedge clk);
        #1 out_ready_a = 1'b0;
        chk("t4_n", 64'(q_a.size()), 2);
        chk("t4_w0", (q_a.size() > 0) ? q_a[0] : '1, {32'h0, 32'h00500093});
        chk("t4_w1", (q_a.size() > 1) ? q_a[1] : '1, {32'h4, 32'h002081B3});
        chk("t4_count", count_a, 2);

        // Address wrap on dut_b, then reset with two entries queued
        do_reset();
        send(1, lui, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345000);
        send(1, imm_arith_type, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5);
        chk("t5_addr0", out_addr_b, 32'hFFFF_FFFC);
        chk("t5_instr0", out_instr_b, 32'h12345137);
        out_ready_b = 1'b1;
        @(posedge clk);
        #1 out_ready_b = 1'b0;
        chk("t5_addr1", out_addr_b, 32'h0);
        chk("t5_instr1", out_instr_b, 32'h00500093);
        send(1, reg_arith_type, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("t5_flush_valid", out_valid_b, 0);
        rst = 1'b0; out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready_b = 1'b0;
        chk("t5_no_words", out_valid_b, 0);
        chk("t5_count", count_b, 0);
        chk("t5_addr_rst", out_addr_b, 32'hFFFF_FFFC);

        // ADDI imm=4096: rejected with range check, truncated otherwise
        do_reset();
        out_ready_a = 1'b1;
        send(0, imm_arith_type, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4096);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        chk("t6_err", err_a, 1);
        repeat (3) @(posedge clk);
        #1 chk("t6_n", 64'(q_a.size()), 0);
`else
        chk("t6_err", err_a, 0);
        repeat (3) @(posedge clk);
        #1 chk("t6_n", 64'(q_a.size()), 1);
        chk("t6_w0", (q_a.size() > 0) ? q_a[0] : '1, {32'h0, 32'h00000093});
`endif
        out_ready_a = 1'b0;

        // Remaining formats, unused fields driven with junk
        do_reset();
        out_ready_a = 1'b1;
        send(0, jal, 5'd0, 5'd31, 5'd31, 3'b111, 7'h7F, 32'hFFFF_FFFC);
        send(0, auipc, 5'd5, 5'd31, 5'd31, 3'b111, 7'h7F, 32'h0000_1000);
        send(0, jalr, 5'd1, 5'd5, 5'd31, 3'b111, 7'h7F, 32'd0);
        send(0, load_type, 5'd6, 5'd2, 5'd31, 3'b010, 7'h7F, 32'hFFFF_FFFC);
        send(0, imm_arith_type, 5'd7, 5'd7, 5'd31, 3'b101, 7'h20, 32'd3);
        send(0, system_type, 5'd0, 5'd0, 5'd31, 3'b000, 7'h7F, 32'd0);
        repeat (4) @(posedge clk);
        #1 out_ready_a = 1'b0;
        chk("t7_n", 64'(q_a.size()), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t7_w%0d", i), (i < q_a.size()) ? q_a[i] : '1, exp7[i]);
        chk("t7_count", count_a, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
